// File: rtl/i2s_tx_if.sv
// Sample-side handshake plus serial audio outputs of the I2S transmitter.
// master = sample source / bus observer, slave = transmitter.
interface i2s_tx_if #(
  parameter int SAMPLE_W = 16
);
  logic [SAMPLE_W-1:0] sample_l;
  logic [SAMPLE_W-1:0] sample_r;
  logic                sample_valid;
  logic                sample_ready;
  logic                bck;
  logic                ws;
  logic                din;
  logic                underrun;

  // valid/ready: a pair transfers on any clk edge where sample_valid && sample_ready;
  // the source holds sample_l/sample_r stable while sample_valid is high and not yet accepted.
  modport master (
    output sample_l, sample_r, sample_valid,
    input  sample_ready, bck, ws, din, underrun
  );

  modport slave (
    input  sample_l, sample_r, sample_valid,
    output sample_ready, bck, ws, din, underrun
  );
endinterface

// File: rtl/i2s_tx.sv
// Stereo I2S / left-justified transmitter: fractional-accumulator BCK,
// one-pair holding register, MSB-first shifter with zero padding to SLOT_W.
module i2s_tx #(
  parameter int CLK_HZ    = 32000000,
  parameter int SAMPLE_HZ = 48000,
  parameter int SAMPLE_W  = 16,
  parameter int SLOT_W    = 16,
  parameter int FORMAT    = 0
) (
  input  logic    clk,
  input  logic    reset_n,
  input  logic    en,
  i2s_tx_if.slave bus,
  output logic    dbg_running
);

  localparam int INC   = 4 * SAMPLE_HZ * SLOT_W;
  localparam int ACC_W = $clog2(CLK_HZ) + 1;
  localparam int CNT_W = $clog2(2 * SLOT_W);

  localparam logic [ACC_W-1:0] INC_C  = ACC_W'(INC);
  localparam logic [ACC_W-1:0] CLK_C  = ACC_W'(CLK_HZ);
  localparam logic [CNT_W-1:0] SLOT_C = CNT_W'(SLOT_W);
  localparam logic [CNT_W-1:0] LAST_C = CNT_W'(2 * SLOT_W - 1);
  localparam logic [CNT_W-1:0] WS_LO  = CNT_W'(SLOT_W - 1);
  localparam logic [CNT_W-1:0] WS_HI  = CNT_W'(2 * SLOT_W - 2);

  if (2 * INC > CLK_HZ) begin : g_rate_err
    $error("i2s_tx: BCK toggle rate exceeds half of CLK_HZ");
  end
  if (SLOT_W < SAMPLE_W) begin : g_slot_err
    $error("i2s_tx: SLOT_W must be >= SAMPLE_W");
  end

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t state, state_nxt;

  logic [ACC_W-1:0]    acc, acc_sum;
  logic                ovf, fall, load;
  logic [CNT_W-1:0]    bit_cnt, cnt_nxt, k;
  logic [SAMPLE_W-1:0] sh_l, sh_r, sh_l_nxt, sh_r_nxt;
  logic [SAMPLE_W-1:0] last_l, last_r, hold_l, hold_r, sel;
  logic [SLOT_W-1:0]   padded, shifted;
  logic                slot_r, ws_nxt, din_nxt;
  logic                bck_q, ws_q, din_q, ready_q, underrun_q;

  assign bus.bck          = bck_q;
  assign bus.ws           = ws_q;
  assign bus.din          = din_q;
  assign bus.sample_ready = ready_q;
  assign bus.underrun     = underrun_q;
  assign dbg_running      = (state == ST_RUN);

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    fall      = 1'b0;
    acc_sum   = acc + INC_C;
    ovf       = (acc_sum >= CLK_C);
    case (state)
      ST_IDLE: begin
        if (en) begin
          state_nxt = ST_RUN;
          load      = 1'b1;
        end
      end
      ST_RUN: begin
        if (!en) begin
          state_nxt = ST_IDLE;
        end else begin
          fall = ovf & bck_q;
          load = fall & (bit_cnt == LAST_C);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    cnt_nxt = load ? '0 : (fall ? bit_cnt + 1'b1 : bit_cnt);

    // An empty holding register means the previous pair is replayed.
    sh_l_nxt = sh_l;
    sh_r_nxt = sh_r;
    if (load) begin
      sh_l_nxt = ready_q ? last_l : hold_l;
      sh_r_nxt = ready_q ? last_r : hold_r;
    end

    if (FORMAT == 1) ws_nxt = (cnt_nxt >= SLOT_C);
    else             ws_nxt = (cnt_nxt >= WS_LO) && (cnt_nxt <= WS_HI);

    slot_r  = (cnt_nxt >= SLOT_C);
    k       = slot_r ? cnt_nxt - SLOT_C : cnt_nxt;
    sel     = slot_r ? sh_r_nxt : sh_l_nxt;
    padded  = SLOT_W'(sel) << (SLOT_W - SAMPLE_W);
    shifted = padded << k;
    din_nxt = shifted[SLOT_W-1];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      acc        <= '0;
      bit_cnt    <= '0;
      sh_l       <= '0;
      sh_r       <= '0;
      last_l     <= '0;
      last_r     <= '0;
      hold_l     <= '0;
      hold_r     <= '0;
      bck_q      <= 1'b0;
      ws_q       <= 1'b0;
      din_q      <= 1'b0;
      ready_q    <= 1'b1;
      underrun_q <= 1'b0;
    end else begin
      state      <= state_nxt;
      underrun_q <= load & ready_q;

      // Load sees the pre-cycle holding state; a same-cycle accept lands for the next frame.
      if (bus.sample_valid && ready_q) begin
        hold_l  <= bus.sample_l;
        hold_r  <= bus.sample_r;
        ready_q <= 1'b0;
      end else if (load && !ready_q) begin
        ready_q <= 1'b1;
      end
      if (load && !ready_q) begin
        last_l <= hold_l;
        last_r <= hold_r;
      end

      if (!en) begin
        acc     <= '0;
        bit_cnt <= '0;
        bck_q   <= 1'b0;
        ws_q    <= 1'b0;
        din_q   <= 1'b0;
      end else begin
        acc <= ovf ? acc_sum - CLK_C : acc_sum;
        if (ovf) bck_q <= ~bck_q;
        if (load || fall) begin
          bit_cnt <= cnt_nxt;
          ws_q    <= ws_nxt;
          din_q   <= din_nxt;
        end
        if (load) begin
          sh_l <= sh_l_nxt;
          sh_r <= sh_r_nxt;
        end
      end
    end
  end

endmodule
